adder_pipe: RTL and testbench

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pipe.sv | 76 +++++++
 tb/tb_adder_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// Valid/ready multi-mode adder: all arithmetic in stage 0, STAGES-1 register stages after; latency STAGES cycles.
// Global stall: every stage holds while valid_o && !ready_i. Optional macro ADDER_SATURATE_EN enables f_i=2'b11 saturation.
module adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       f_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] y_o,
  output logic             carry_o,
  output logic             ovf_o
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             carry;
    logic             ovf;
  } res_t;

  logic [WIDTH:0]            sum;
  logic [WIDTH-1:0]          eac;
  logic                      sgn_ovf;
  logic                      adv;
  res_t                      res_d;
  logic [STAGES-1:0]         vld_q;
  res_t [STAGES-1:0]         res_q;

  always_comb begin
    sum           = {1'b0, a_i} + {1'b0, b_i};
    // End-around carry cannot wrap again: the low part is at most 2^WIDTH-2 when the carry is set.
    eac           = sum[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, sum[WIDTH]};
    res_d         = '0;
    res_d.carry   = sum[WIDTH];
    res_d.y       = (f_i == 2'b01) ? eac : sum[WIDTH-1:0];
    sgn_ovf       = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res_d.y[WIDTH-1] != a_i[WIDTH-1]);
    res_d.ovf     = (f_i == 2'b00) ? sum[WIDTH] : sgn_ovf;
`ifdef ADDER_SATURATE_EN
    if (f_i == 2'b11 && sgn_ovf) begin
      res_d.y = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  assign valid_o = vld_q[STAGES-1];
  assign y_o     = res_q[STAGES-1].y;
  assign carry_o = res_q[STAGES-1].carry;
  assign ovf_o   = res_q[STAGES-1].ovf;
  assign ready_o = !valid_o || ready_i;
  assign adv     = ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      res_q <= '0;
    end else if (adv) begin
      vld_q[0] <= valid_i;
      if (valid_i) begin
        res_q[0] <= res_d;
      end
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          res_q[i] <= res_q[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe (WIDTH=4, STAGES=2): driver pushes hand-computed results, negedge monitor pops and compares.
module tb_adder_pipe;
  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic         ready_o;
  logic [1:0]   f_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] y_o;
  logic         carry_o;
  logic         ovf_o;

  logic [W-1:0] exp_y;
  logic         exp_c;
  logic         exp_o;

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    logic         o;
    int           acc;
    int           st;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   stall_cnt = 0;

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .f_i(f_i), .a_i(a_i), .b_i(b_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .y_o(y_o), .carry_o(carry_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor and scoreboard bookkeeping, all at the negative edge.
  initial begin
    exp_t         e;
    logic         hold = 1'b0;
    logic [W-1:0] hy;
    logic         hc, ho;
    forever begin
      @(negedge clk);
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {31'd0, valid_o}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result_y", y_o, e.y);
          chk("result_flags", {carry_o, ovf_o}, {e.c, e.o});
          chk("latency", cyc - e.acc - (stall_cnt - e.st), S);
        end
      end
      if (hold) begin
        chk("stall_stable", {valid_o, y_o, carry_o, ovf_o}, {1'b1, hy, hc, ho});
      end
      hold = valid_o && !ready_i && !rst;
      hy = y_o; hc = carry_o; ho = ovf_o;
      if (rst) sb.delete();
      else if (valid_i && ready_o) begin
        e.y = exp_y; e.c = exp_c; e.o = exp_o; e.acc = cyc; e.st = stall_cnt;
        sb.push_back(e);
      end
      if (valid_o && !ready_i) stall_cnt++;
      cyc++;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] ey, input logic ec, input logic eo);
    int w;
    f_i = f; a_i = a; b_i = b;
    exp_y = ey; exp_c = ec; exp_o = eo;
    valid_i = 1'b1;
    w = 0;
    @(negedge clk);
    while (!ready_o && w < 20) begin
      w++;
      @(negedge clk);
    end
    if (!ready_o) chk("accept_timeout", {31'd0, ready_o}, 32'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [1:0]   vf [12] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b11};
  logic [W-1:0] va [12] = '{4'hF, 4'hF, 4'hF, 4'h7, 4'h7, 4'h8, 4'h3, 4'h8, 4'hC, 4'h5, 4'hA, 4'h2};
  logic [W-1:0] vb [12] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'hF, 4'h4, 4'h8, 4'hD, 4'hA, 4'h7, 4'h3};
`ifdef ADDER_SATURATE_EN
  logic [W-1:0] vy [12] = '{4'h0, 4'h1, 4'h0, 4'h8, 4'h7, 4'h8, 4'h7, 4'h1, 4'h9, 4'hF, 4'h1, 4'h5};
`else
  logic [W-1:0] vy [12] = '{4'h0, 4'h1, 4'h0, 4'h8, 4'h8, 4'h7, 4'h7, 4'h1, 4'h9, 4'hF, 4'h1, 4'h5};
`endif
  logic         vc [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic         vo [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    f_i = '0; a_i = '0; b_i = '0;
    exp_y = '0; exp_c = 1'b0; exp_o = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid_o", {31'd0, valid_o}, 32'd0);
    chk("reset_outputs", {y_o, carry_o, ovf_o}, 6'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready_o", {31'd0, ready_o}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back directed vectors with per-beat mode changes.
    for (int i = 0; i < 12; i++) send(vf[i], va[i], vb[i], vy[i], vc[i], vo[i]);
    drain();

    // Six-beat stream with a three-cycle downstream stall.
    fork
      begin
        for (int i = 0; i < 6; i++) send(2'b00, 4'(i), 4'd1, 4'(i + 1), 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_ready_o", {31'd0, ready_o}, 32'd0);
        end
        @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight: they must be discarded.
    send(2'b10, 4'h3, 4'h2, 4'h5, 1'b0, 1'b0);
    send(2'b10, 4'h1, 4'h1, 4'h2, 1'b0, 1'b0);
    ready_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    chk("flush_valid_o", {31'd0, valid_o}, 32'd0);
    chk("flush_y_o", y_o, 0);
    chk("flush_ready_o", {31'd0, ready_o}, 32'd1);
    @(posedge clk);
    #1;
    send(2'b00, 4'h6, 4'h6, 4'hC, 1'b0, 1'b0);
    drain();
    repeat (3) @(posedge clk);
    chk("sb_empty_end", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
